// File: rtl/cpu_instr_issuer.sv
// Instruction issuer for the combinational CPU: queues (op, a, b) triples, drives each packed
// instruction for SETTLE cycles, samples the CPU result and returns it over valid/ready.
`timescale 1ns/1ps

module cpu_instr_issuer #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned SETTLE = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_op,
   input  logic [7:0]               in_a,
   input  logic [7:0]               in_b,
   output logic [18:0]              instruction,
   input  logic [7:0]               cpu_result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2:0]               out_op,
   output logic [7:0]               out_result,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [AW:0]   CountOne   = (AW+1)'(1);
   localparam logic [AW:0]   CountFull  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PtrOne     = AW'(1);
   localparam logic [CW-1:0] CntOne     = CW'(1);
   localparam logic [CW-1:0] SettleLoad = CW'(SETTLE - 1);

   typedef enum logic [1:0] {StIdle, StDrive, StHold} state_e;

   state_e         state_q, state_d;
   logic [18:0]    mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [AW:0]    count_q, count_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [18:0]    instr_q, instr_d;
   logic           valid_q, valid_d;
   logic [2:0]     op_q, op_d;
   logic [7:0]     res_q, res_d;
   logic           push, pop;

   assign in_ready    = (count_q != CountFull);
   assign push        = in_valid && in_ready;
   assign instruction = instr_q;
   assign out_valid   = valid_q;
   assign out_op      = op_q;
   assign out_result  = res_q;
   assign busy        = (state_q != StIdle);
   assign count       = count_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      instr_d = instr_q;
      valid_d = valid_q;
      op_d    = op_q;
      res_d   = res_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            // count_q excludes a same-edge push, so a fresh entry issues one edge later
            if (count_q != '0) begin
               pop     = 1'b1;
               cnt_d   = SettleLoad;
               state_d = StDrive;
            end
         end
         StDrive: begin
            if (cnt_q == '0) begin
               res_d   = cpu_result;
               op_d    = instr_q[18:16];
               valid_d = 1'b1;
               state_d = StHold;
            end else begin
               cnt_d = cnt_q - CntOne;
            end
         end
         StHold: begin
            if (out_ready) begin
               valid_d = 1'b0;
               if (count_q != '0) begin
                  pop     = 1'b1;
                  cnt_d   = SettleLoad;
                  state_d = StDrive;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (pop) instr_d = mem_q[rd_ptr_q];
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CountOne;
      else if (!push && pop) count_d = count_q - CountOne;
   end

   // Storage is not reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {in_op, in_a, in_b};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         cnt_q    <= '0;
         instr_q  <= '0;
         valid_q  <= 1'b0;
         op_q     <= '0;
         res_q    <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         cnt_q    <= cnt_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         op_q     <= op_d;
         res_q    <= res_d;
         if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      end
   end

endmodule

// File: tb/tb_cpu_instr_issuer.sv
// Bench for cpu_instr_issuer: directed timing scenarios plus random traffic, with results
// checked against a queue of pushed triples and a stub CPU computing a ^ b.
`timescale 1ns/1ps

module tb_cpu_instr_issuer;

   localparam int DEPTH  = 8;
   localparam int SETTLE = 2;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   in_valid;
   logic                   in_ready;
   logic [2:0]             in_op;
   logic [7:0]             in_a;
   logic [7:0]             in_b;
   logic [18:0]            instruction;
   logic [7:0]             cpu_result;
   logic                   out_valid;
   logic                   out_ready;
   logic [2:0]             out_op;
   logic [7:0]             out_result;
   logic                   busy;
   logic [$clog2(DEPTH):0] count;

   logic [7:0] noise;
   int checks   = 0;
   int failures = 0;
   int cycle    = 0;
   logic [18:0] exp_q[$];
   int hs_cycles[$];

   cpu_instr_issuer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .instruction(instruction), .cpu_result(cpu_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_result(out_result),
      .busy(busy), .count(count)
   );

   always #5 clk = ~clk;

   // Stub CPU; noise lets a test disturb the result while it must be ignored.
   assign cpu_result = instruction[15:8] ^ instruction[7:0] ^ noise;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_rand_in();
      in_op = 3'($urandom_range(0, 7));
      in_a  = 8'($urandom);
      in_b  = 8'($urandom);
   endtask

   // One clock edge; handshakes seen before the edge update the scoreboard.
   task automatic step();
      logic        do_push, do_pop;
      logic [18:0] trip, e;
      logic [2:0]  o_op;
      logic [7:0]  o_res;
      do_push = in_valid && in_ready;
      do_pop  = out_valid && out_ready;
      trip    = {in_op, in_a, in_b};
      o_op    = out_op;
      o_res   = out_result;
      @(posedge clk);
      #1;
      cycle++;
      if (do_push) exp_q.push_back(trip);
      if (do_pop) begin
         hs_cycles.push_back(cycle);
         checks++;
         assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL stray_result observed=op%0d/0x%0h expected=none", o_op, o_res);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_op", 32'(o_op), 32'(e[18:16]));
            check("out_result", 32'(o_res), 32'(e[15:8] ^ e[7:0]));
         end
      end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 50) begin
         step();
         n++;
      end
      check("out_valid_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((busy || count != 0) && n < 300) begin
         step();
         n++;
      end
      check("drain_idle", 32'(busy), 32'd0);
      check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int peak, ir_low, accepted, n;
      logic [18:0] held_instr, second;
      logic [7:0]  held_res;
      logic [2:0]  held_op;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; noise = 8'h00;
      in_op = '0; in_a = '0; in_b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_instruction", 32'(instruction), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_op", 32'(out_op), 32'd0);
      check("rst_out_result", 32'(out_result), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      step();

      // Single op: push at edge 0, result valid after edge 3, idle after edge 4.
      out_ready = 1'b1; in_valid = 1'b1; in_op = 3'd3; in_a = 8'h5A; in_b = 8'h0F;
      step();
      in_valid = 1'b0;
      check("single_e0_instr", 32'(instruction), 32'd0);
      check("single_e0_busy", 32'(busy), 32'd0);
      step();
      check("single_e1_instr", 32'(instruction), 32'h35A0F);
      check("single_e1_busy", 32'(busy), 32'd1);
      step();
      check("single_e2_valid", 32'(out_valid), 32'd0);
      step();
      check("single_e3_valid", 32'(out_valid), 32'd1);
      check("single_e3_result", 32'(out_result), 32'h55);
      check("single_e3_op", 32'(out_op), 32'd3);
      step();
      check("single_e4_busy", 32'(busy), 32'd0);
      check("single_e4_valid", 32'(out_valid), 32'd0);

      // Burst of 8: issues at edges 1,4,7 leave at most 5 queued.
      peak = 0; ir_low = 0; hs_cycles.delete();
      for (int i = 0; i < 8; i++) begin
         set_rand_in();
         in_valid = 1'b1;
         if (!in_ready) ir_low = 1;
         step();
         if (int'(count) > peak) peak = int'(count);
      end
      drain();
      check("burst_peak_count", 32'(peak), 32'd5);
      check("burst_in_ready_low", 32'(ir_low), 32'd0);
      check("burst_results", 32'(hs_cycles.size()), 32'd8);
      for (int i = 1; i < hs_cycles.size(); i++)
         check("burst_spacing", 32'(hs_cycles[i] - hs_cycles[i-1]), 32'(SETTLE + 1));

      // Full FIFO: 8 queued + 1 in flight, the 10th waits for a handshake.
      out_ready = 1'b0; accepted = 0; n = 0;
      while (accepted < 9 && n < 30) begin
         set_rand_in();
         in_valid = 1'b1;
         if (in_ready) accepted++;
         step();
         n++;
      end
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_count", 32'(count), 32'(DEPTH));
      set_rand_in();
      repeat (3) step();
      check("full_held_count", 32'(count), 32'(DEPTH));
      check("full_held_queue", 32'(exp_q.size()), 32'd9);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("full_after_hs_count", 32'(count), 32'(DEPTH - 1));
      check("full_after_hs_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check("full_tenth_accepted", 32'(count), 32'(DEPTH));
      drain();

      // Backpressure: outputs frozen while the CPU result wanders.
      out_ready = 1'b0;
      set_rand_in();
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_valid();
      held_res = out_result; held_op = out_op; held_instr = instruction;
      for (int i = 0; i < 20; i++) begin
         noise = 8'($urandom_range(1, 255));
         step();
         check("bp_result", 32'(out_result), 32'(held_res));
         check("bp_op", 32'(out_op), 32'(held_op));
         check("bp_instr", 32'(instruction), 32'(held_instr));
      end
      noise = 8'h00;
      drain();

      // Simultaneous push and handshake with 4 queued.
      out_ready = 1'b0;
      second = '0;
      for (int i = 0; i < 5; i++) begin
         set_rand_in();
         in_valid = 1'b1;
         if (i == 1) second = {in_op, in_a, in_b};
         step();
      end
      in_valid = 1'b0;
      wait_valid();
      check("sim_pre_count", 32'(count), 32'd4);
      set_rand_in();
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      check("sim_count", 32'(count), 32'd4);
      check("sim_instr", 32'(instruction), 32'(second));
      check("sim_valid", 32'(out_valid), 32'd0);
      drain();

      // Reset mid-DRIVE with 3 entries queued.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_rand_in();
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      wait_valid();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("rstmid_pre_count", 32'(count), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_valid", 32'(out_valid), 32'd0);
      check("rstmid_count", 32'(count), 32'd0);
      check("rstmid_instr", 32'(instruction), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      exp_q.delete();
      #10 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("rstmid_no_stale", 32'(out_valid), 32'd0);
      end

      // Random traffic against the scoreboard.
      for (int i = 0; i < 400; i++) begin
         set_rand_in();
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
